// File: rtl/syncram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port synchronous RAM:
// clear-sequencer state encoding, read-during-write mode constants and the
// byte-lane merge function used for write-first read data.
package syncram_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers cast in and out.
    localparam int MERGE_W = 512;

    // Replace every byte lane of old_word whose enable bit is set with the
    // corresponding lane of new_word. Lane k covers bits [k*byte_w +: byte_w].
    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] be,
        input int                 byte_w
    );
        logic [MERGE_W-1:0] res;
        int                 lane;
        res = old_word;
        for (int b = 0; b < MERGE_W; b++) begin
            lane = b / byte_w;
            if (be[lane]) begin
                res[b] = new_word[b];
            end else begin
                res[b] = old_word[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/syncram_dp_be_if.sv
// Request/response bundle for both ports of syncram_dp_be.
// master: the requester (core / DMA); slave: the RAM.
interface syncram_dp_be_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 10,
    parameter int BYTE_W = 8
);
    localparam int NBE = WIDTH / BYTE_W;

    logic [DEPTH-1:0] address_a;
    logic [WIDTH-1:0] data_a;
    logic [NBE-1:0]   be_a;
    logic             rden_a;
    logic             wren_a;
    logic [WIDTH-1:0] q_a;
    logic             qvalid_a;

    logic [DEPTH-1:0] address_b;
    logic [WIDTH-1:0] data_b;
    logic [NBE-1:0]   be_b;
    logic             rden_b;
    logic             wren_b;
    logic [WIDTH-1:0] q_b;
    logic             qvalid_b;

    modport master (
        output address_a, data_a, be_a, rden_a, wren_a,
        output address_b, data_b, be_b, rden_b, wren_b,
        input  q_a, qvalid_a, q_b, qvalid_b
    );

    modport slave (
        input  address_a, data_a, be_a, rden_a, wren_a,
        input  address_b, data_b, be_b, rden_b, wren_b,
        output q_a, qvalid_a, q_b, qvalid_b
    );

endinterface

// File: rtl/syncram_clear_fsm.sv
// Post-reset memory-clear sequencer. Walks the word address from 0 to
// WORDS-1, one word per cycle, then raises init_done. With CLEAR_ON_RST=0
// it skips the walk and raises init_done one cycle after reset release.
module syncram_clear_fsm
    import syncram_pkg::*;
#(
    parameter int WORDS        = 1024,
    parameter int CLEAR_ON_RST = 1,
    parameter int IDX_W        = 10
) (
    input  logic             clock,
    input  logic             rst_n,
    output logic [IDX_W-1:0] clr_addr,
    output logic             clr_we,
    output logic             init_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    clr_state_e       state_r;
    clr_state_e       state_s;
    logic [IDX_W-1:0] cnt_r;
    logic [IDX_W-1:0] cnt_s;
    logic             init_done_r;

    // State, counter and registered init_done; reset restarts the walk at word 0.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r     <= CLR_IDLE;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            init_done_r <= (state_s == CLR_DONE);
        end
    end

    // Next-state and counter advance.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            CLR_IDLE: begin
                cnt_s = '0;
                if (CLEAR_ON_RST != 0) begin
                    state_s = CLR_RUN;
                end else begin
                    state_s = CLR_DONE;
                end
            end
            CLR_RUN: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = CLR_DONE;
                end else begin
                    cnt_s = cnt_r + IDX_W'(1);
                end
            end
            CLR_DONE: begin
                state_s = CLR_DONE;
            end
            default: begin
                state_s = CLR_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    assign clr_addr  = cnt_r;
    assign clr_we    = (state_r == CLR_RUN);
    assign init_done = init_done_r;

endmodule

// File: rtl/syncram_dp_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable
// same-port read-during-write (read-first / write-first), optional output
// register stage, read-valid strobes and a post-reset clear sequencer.
// Port A wins per-byte on same-address write collisions; a read of a word
// written in the same cycle by the other port always returns old data.
// Optional: define SYNCRAM_COLLISION_CNT_EN to add the 16-bit saturating
// write-write collision counter output coll_cnt.
module syncram_dp_be
    import syncram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 10,
    parameter int WORDS        = 1024,
    parameter int BYTE_W       = 8,
    parameter int OUT_REG      = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    syncram_dp_be_if.slave       bus,
    output logic                 init_done
`ifdef SYNCRAM_COLLISION_CNT_EN
    ,
    output logic [15:0]          coll_cnt
`endif
);

    localparam int NBE   = WIDTH / BYTE_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [WIDTH-1:0] mem [0:WORDS-1];

    logic [IDX_W-1:0] clr_addr_s;
    logic             clr_we_s;
    logic             init_done_s;

    logic             accept_s;
    logic             in_range_a_s;
    logic             in_range_b_s;
    logic [IDX_W-1:0] idx_a_s;
    logic [IDX_W-1:0] idx_b_s;
    logic             rd_a_s;
    logic             rd_b_s;
    logic             wr_a_s;
    logic             wr_b_s;
    logic [NBE-1:0]   be_a_eff_s;
    logic [NBE-1:0]   be_b_eff_s;
    logic [WIDTH-1:0] rd_word_a_s;
    logic [WIDTH-1:0] rd_word_b_s;

    logic [WIDTH-1:0] q1_a_r;
    logic [WIDTH-1:0] q1_b_r;
    logic             v1_a_r;
    logic             v1_b_r;

    syncram_clear_fsm #(
        .WORDS        (WORDS),
        .CLEAR_ON_RST (CLEAR_ON_RST),
        .IDX_W        (IDX_W)
    ) u_clear (
        .clock     (clock),
        .rst_n     (rst_n),
        .clr_addr  (clr_addr_s),
        .clr_we    (clr_we_s),
        .init_done (init_done_s)
    );

    assign init_done = init_done_s;

    // Requests are only honoured once the memory is usable and not in reset.
    assign accept_s     = rst_n & init_done_s;
    assign in_range_a_s = (32'(bus.address_a) < 32'(WORDS));
    assign in_range_b_s = (32'(bus.address_b) < 32'(WORDS));
    assign idx_a_s      = bus.address_a[IDX_W-1:0];
    assign idx_b_s      = bus.address_b[IDX_W-1:0];
    assign rd_a_s       = bus.rden_a & accept_s;
    assign rd_b_s       = bus.rden_b & accept_s;
    assign wr_a_s       = bus.wren_a & accept_s & in_range_a_s;
    assign wr_b_s       = bus.wren_b & accept_s & in_range_b_s;
    assign be_a_eff_s   = wr_a_s ? bus.be_a : '0;
    assign be_b_eff_s   = wr_b_s ? bus.be_b : '0;

    // Memory array: clear writes first; otherwise B lanes then A lanes, so
    // the later A assignment wins any lane both ports enable.
    always_ff @(posedge clock) begin
        if (clr_we_s) begin
            mem[clr_addr_s] <= '0;
        end else begin
            for (int i = 0; i < NBE; i++) begin
                if (be_b_eff_s[i]) begin
                    mem[idx_b_s][i*BYTE_W +: BYTE_W] <= bus.data_b[i*BYTE_W +: BYTE_W];
                end
                if (be_a_eff_s[i]) begin
                    mem[idx_a_s][i*BYTE_W +: BYTE_W] <= bus.data_a[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Port A read word: zero out of range, old or own-merged word otherwise.
    always_comb begin
        rd_word_a_s = '0;
        if (!in_range_a_s) begin
            rd_word_a_s = '0;
        end else if (RDW_MODE == RDW_WRITE_FIRST) begin
            rd_word_a_s = WIDTH'(merge_be(MERGE_W'(mem[idx_a_s]), MERGE_W'(bus.data_a),
                                          MERGE_W'(be_a_eff_s), BYTE_W));
        end else begin
            rd_word_a_s = mem[idx_a_s];
        end
    end

    // Port B read word: zero out of range, old or own-merged word otherwise.
    always_comb begin
        rd_word_b_s = '0;
        if (!in_range_b_s) begin
            rd_word_b_s = '0;
        end else if (RDW_MODE == RDW_WRITE_FIRST) begin
            rd_word_b_s = WIDTH'(merge_be(MERGE_W'(mem[idx_b_s]), MERGE_W'(bus.data_b),
                                          MERGE_W'(be_b_eff_s), BYTE_W));
        end else begin
            rd_word_b_s = mem[idx_b_s];
        end
    end

    // First read stage: capture data on accepted reads, hold otherwise.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            q1_a_r <= '0;
            q1_b_r <= '0;
            v1_a_r <= 1'b0;
            v1_b_r <= 1'b0;
        end else begin
            v1_a_r <= rd_a_s;
            v1_b_r <= rd_b_s;
            if (rd_a_s) begin
                q1_a_r <= rd_word_a_s;
            end
            if (rd_b_s) begin
                q1_b_r <= rd_word_b_s;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] q2_a_r;
            logic [WIDTH-1:0] q2_b_r;
            logic             v2_a_r;
            logic             v2_b_r;

            // Extra output stage: forward stage-1 data only when it is valid.
            always_ff @(posedge clock) begin
                if (!rst_n) begin
                    q2_a_r <= '0;
                    q2_b_r <= '0;
                    v2_a_r <= 1'b0;
                    v2_b_r <= 1'b0;
                end else begin
                    v2_a_r <= v1_a_r;
                    v2_b_r <= v1_b_r;
                    if (v1_a_r) begin
                        q2_a_r <= q1_a_r;
                    end
                    if (v1_b_r) begin
                        q2_b_r <= q1_b_r;
                    end
                end
            end

            assign bus.q_a      = q2_a_r;
            assign bus.qvalid_a = v2_a_r;
            assign bus.q_b      = q2_b_r;
            assign bus.qvalid_b = v2_b_r;
        end else begin : g_no_out_reg
            assign bus.q_a      = q1_a_r;
            assign bus.qvalid_a = v1_a_r;
            assign bus.q_b      = q1_b_r;
            assign bus.qvalid_b = v1_b_r;
        end
    endgenerate

`ifdef SYNCRAM_COLLISION_CNT_EN
    logic        coll_s;
    logic [15:0] coll_cnt_r;

    assign coll_s = wr_a_s & wr_b_s & (bus.address_a == bus.address_b);

    // Saturating count of same-address write-write cycles.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            coll_cnt_r <= 16'd0;
        end else if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
            coll_cnt_r <= coll_cnt_r + 16'd1;
        end
    end

    assign coll_cnt = coll_cnt_r;
`endif

endmodule
